stack_seq: RTL

STACK_SEQ -- requirements
Module: stack_seq

---
 rtl/stack_seq_if.sv | 37 +++
 rtl/stack_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq_if.sv
// stack_seq_if: command/response and stack-side signals of the stack sequencer.
//   req/cmd/wdata        : command request from the issuer
//   busy/done/err        : sequencer status; err is meaningful while done=1
//   opa/opb/opc          : entries popped by the last POP/SELECT
//   depth                : current operand stack entry count
//   stack_op/stack_data  : operation and entry presented to the stack storage
//   stack_tos            : top-of-stack entry returned by the stack storage
// The slave modport is the sequencer; the master modport is the issuer plus
// the stack storage.
interface stack_seq_if #(
  parameter int WIDTH = 66,
  parameter int DW    = 4
);
  logic             req;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [1:0]       err;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] opc;
  logic [DW-1:0]    depth;
  logic [1:0]       stack_op;
  logic [WIDTH-1:0] stack_data;
  logic [WIDTH-1:0] stack_tos;

  modport slave (
    input  req, cmd, wdata, stack_tos,
    output busy, done, err, opa, opb, opc, depth, stack_op, stack_data
  );

  modport master (
    output req, cmd, wdata, stack_tos,
    input  busy, done, err, opa, opb, opc, depth, stack_op, stack_data
  );
endinterface

// File: rtl/stack_seq.sv
// stack_seq: sequences operand-stack commands (NOP, PUSH, POP1..3, REPLACE,
// SELECT) against an external stack that applies stack_op at the end of the
// cycle it is shown and presents the new top on stack_tos the cycle after.
// Entries are {type[1:0], value}; types i32=0, i64=1, f32=2, f64=3.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : stack_seq_if slave modport (see interface for signal list)
// All outputs come straight from registers.
//
// state | meaning
// IDLE  | waiting for req; busy=0
// CAP   | stack_tos is valid: latch it into an op slot and register a POP
// WAIT  | the registered POP is visible to the stack
// CHK   | SELECT only: latch val1, check types, decide on REPLACE
// DONE  | completion pulse cycle; busy=0, a new req is accepted here
module stack_seq #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input logic       clk_i,
  input logic       rst_i,
  stack_seq_if.slave bus
);

  localparam logic [1:0] OP_NONE = 2'd0, OP_PUSH = 2'd1, OP_POP = 2'd2, OP_REPL = 2'd3;
  localparam logic [1:0] ERR_NONE = 2'd0, ERR_UNDER = 2'd1, ERR_OVER = 2'd2, ERR_TYPE = 2'd3;
  localparam logic [1:0] TYPE_I32 = 2'd0;
  localparam logic [2:0] CMD_PUSH = 3'd1, CMD_POP1 = 3'd2, CMD_POP2 = 3'd3, CMD_POP3 = 3'd4,
                         CMD_REPL = 3'd5, CMD_SEL  = 3'd6;
  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
  localparam logic [DW-1:0] SEL_MIN = DW'(3);

  typedef enum logic [2:0] {IDLE, CAP, WAIT, CHK, DONE} state_t;

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       err_q;
  logic [WIDTH-1:0] opa_q, opb_q, opc_q;
  logic [DW-1:0]    depth_q;
  logic [1:0]       stack_op_q;
  logic [WIDTH-1:0] stack_data_q;
  logic [1:0]       rem_q;   // pops still to issue
  logic [1:0]       idx_q;   // op slot for the next CAP
  logic             sel_q;

  logic [DW-1:0] pop_n;
  logic [1:0]    tos_type;
  logic [1:0]    opb_type;

  // POP1..POP3 are encoded 2..4, so the pop count is cmd-1.
  assign pop_n    = DW'(bus.cmd) - DW'(1);
  assign tos_type = bus.stack_tos[WIDTH-1 -: 2];
  assign opb_type = opb_q[WIDTH-1 -: 2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_NONE;
      opa_q        <= '0;
      opb_q        <= '0;
      opc_q        <= '0;
      depth_q      <= '0;
      stack_op_q   <= OP_NONE;
      stack_data_q <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      sel_q        <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= ERR_NONE;
      stack_op_q <= OP_NONE;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (bus.req) begin
            case (bus.cmd)
              CMD_PUSH: begin
                done_q  <= 1'b1;
                state_q <= DONE;
                if (depth_q < DEPTH_C) begin
                  stack_op_q   <= OP_PUSH;
                  stack_data_q <= bus.wdata;
                  depth_q      <= depth_q + 1'b1;
                end else begin
                  err_q <= ERR_OVER;
                end
              end
              CMD_REPL: begin
                done_q  <= 1'b1;
                state_q <= DONE;
                if (depth_q != '0) begin
                  stack_op_q   <= OP_REPL;
                  stack_data_q <= bus.wdata;
                end else begin
                  err_q <= ERR_UNDER;
                end
              end
              CMD_POP1, CMD_POP2, CMD_POP3: begin
                if (depth_q < pop_n) begin
                  done_q  <= 1'b1;
                  err_q   <= ERR_UNDER;
                  state_q <= DONE;
                end else begin
                  busy_q  <= 1'b1;
                  state_q <= CAP;
                  rem_q   <= pop_n[1:0];
                  idx_q   <= '0;
                  sel_q   <= 1'b0;
                end
              end
              CMD_SEL: begin
                if (depth_q < SEL_MIN) begin
                  done_q  <= 1'b1;
                  err_q   <= ERR_UNDER;
                  state_q <= DONE;
                end else begin
                  // cond and val2 are popped through CAP/WAIT; val1 stays on
                  // the stack and is read in CHK.
                  busy_q  <= 1'b1;
                  state_q <= CAP;
                  rem_q   <= 2'd2;
                  idx_q   <= '0;
                  sel_q   <= 1'b1;
                end
              end
              default: begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            endcase
          end
        end
        CAP: begin
          if (sel_q && idx_q == 2'd0 && tos_type != TYPE_I32) begin
            done_q  <= 1'b1;
            err_q   <= ERR_TYPE;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            if (sel_q) begin
              if (idx_q == 2'd0) opc_q <= bus.stack_tos;
              else               opb_q <= bus.stack_tos;
            end else begin
              case (idx_q)
                2'd0:    opa_q <= bus.stack_tos;
                2'd1:    opb_q <= bus.stack_tos;
                default: opc_q <= bus.stack_tos;
              endcase
            end
            stack_op_q <= OP_POP;
            depth_q    <= depth_q - 1'b1;
            idx_q      <= idx_q + 2'd1;
            rem_q      <= rem_q - 2'd1;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (rem_q != 2'd0) begin
            state_q <= CAP;
          end else if (sel_q) begin
            state_q <= CHK;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        CHK: begin
          opa_q   <= bus.stack_tos;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
          if (tos_type != opb_type) begin
            err_q <= ERR_TYPE;
          end else if (opc_q[31:0] == 32'd0) begin
            stack_op_q   <= OP_REPL;
            stack_data_q <= opb_q;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.opa        = opa_q;
  assign bus.opb        = opb_q;
  assign bus.opc        = opc_q;
  assign bus.depth      = depth_q;
  assign bus.stack_op   = stack_op_q;
  assign bus.stack_data = stack_data_q;

endmodule
